// File: rtl/calckit_top.sv
// CalcKit matrix-input path: UART RX/echo, decimal parser and matrix-entry FSM
// storing up to two m x n matrices per dimension spec in on-chip memory.

module calckit_mem #(
    parameter int unsigned DEPTH = 1600,
    parameter int unsigned AW    = 11
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);
    logic [7:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) mem[i_waddr] <= i_wdata;
        o_rdata <= mem[i_raddr];
    end
endmodule

module calckit_top #(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic        sys_clk_in,
    input  logic        sys_rst_n,
    input  logic        PC_Uart_rxd,
    output logic        PC_Uart_txd,
    input  logic [4:0]  btn_pin,
    input  logic [7:0]  sw_pin,
    input  logic [7:0]  dip_pin,
    output logic [15:0] led_pin,
    output logic [7:0]  seg_cs_pin,
    output logic [7:0]  seg_data_0_pin,
    output logic [7:0]  seg_data_1_pin
);
    localparam int unsigned MAX_DIM        = 5;
    localparam int unsigned SLOT_WORDS     = 32;
    localparam int unsigned SLOTS_PER_SPEC = 2;
    localparam int unsigned N_SPECS        = MAX_DIM * MAX_DIM;
    localparam int unsigned MEM_WORDS      = N_SPECS * SLOTS_PER_SPEC * SLOT_WORDS;
    localparam int unsigned AW             = $clog2(MEM_WORDS);
    localparam int unsigned BIT_CYC        = CLK_HZ / BAUD;
    localparam int unsigned CW             = $clog2(BIT_CYC) + 1;
    localparam logic [CW-1:0] BIT_LAST     = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST    = CW'(BIT_CYC / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_GET_M = 3'd1, S_GET_N = 3'd2, S_CLEAR = 3'd3, S_GET_DATA = 3'd4
    } state_t;

    // UART receiver
    rx_state_t     r_rx_st;
    logic          r_rx_s1, r_rx_s2, r_rx_s3;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_sh, r_rx_byte;
    logic          r_rx_valid;

    always_ff @(posedge sys_clk_in) begin
        if (!sys_rst_n) begin
            r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_s3 <= 1'b1;
            r_rx_st <= RX_IDLE; r_rx_cnt <= '0; r_rx_bit <= '0;
            r_rx_sh <= '0; r_rx_byte <= '0; r_rx_valid <= 1'b0;
        end else begin
            r_rx_s1    <= PC_Uart_rxd;
            r_rx_s2    <= r_rx_s1;
            r_rx_s3    <= r_rx_s2;
            r_rx_valid <= 1'b0;
            case (r_rx_st)
                RX_IDLE: if (r_rx_s3 && !r_rx_s2) begin
                    r_rx_st  <= RX_START;
                    r_rx_cnt <= '0;
                end
                RX_START: if (r_rx_cnt == HALF_LAST) begin
                    r_rx_cnt <= '0;
                    r_rx_bit <= '0;
                    r_rx_st  <= r_rx_s2 ? RX_IDLE : RX_DATA;
                end else r_rx_cnt <= r_rx_cnt + CW'(1);
                RX_DATA: if (r_rx_cnt == BIT_LAST) begin
                    r_rx_cnt <= '0;
                    r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                    r_rx_bit <= r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) r_rx_st <= RX_STOP;
                end else r_rx_cnt <= r_rx_cnt + CW'(1);
                RX_STOP: if (r_rx_cnt == BIT_LAST) begin
                    // framing error silently drops the byte
                    r_rx_valid <= r_rx_s2;
                    r_rx_byte  <= r_rx_sh;
                    r_rx_st    <= RX_IDLE;
                end else r_rx_cnt <= r_rx_cnt + CW'(1);
                default: r_rx_st <= RX_IDLE;
            endcase
        end
    end

    // UART echo transmitter; bytes arriving while busy are not echoed
    logic          r_txd, r_tx_busy;
    logic [8:0]    r_tx_sh;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_nbit;

    always_ff @(posedge sys_clk_in) begin
        if (!sys_rst_n) begin
            r_txd <= 1'b1; r_tx_busy <= 1'b0; r_tx_sh <= '0;
            r_tx_cnt <= '0; r_tx_nbit <= '0;
        end else if (!r_tx_busy) begin
            if (r_rx_valid) begin
                r_tx_busy <= 1'b1;
                r_txd     <= 1'b0;
                r_tx_sh   <= {1'b1, r_rx_byte};
                r_tx_cnt  <= '0;
                r_tx_nbit <= '0;
            end
        end else if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_nbit == 4'd9) r_tx_busy <= 1'b0;
            else begin
                r_txd     <= r_tx_sh[0];
                r_tx_sh   <= {1'b1, r_tx_sh[8:1]};
                r_tx_nbit <= r_tx_nbit + 4'd1;
            end
        end else r_tx_cnt <= r_tx_cnt + CW'(1);
    end

    // Confirm button: synchroniser plus rising-edge pulse
    logic r_btn_s1, r_btn_s2, r_btn_s3;
    logic w_confirm;

    always_ff @(posedge sys_clk_in) begin
        if (!sys_rst_n) begin
            r_btn_s1 <= 1'b0; r_btn_s2 <= 1'b0; r_btn_s3 <= 1'b0;
        end else begin
            r_btn_s1 <= btn_pin[2];
            r_btn_s2 <= r_btn_s1;
            r_btn_s3 <= r_btn_s2;
        end
    end
    assign w_confirm = r_btn_s2 & ~r_btn_s3;

    // Decimal parser: digits accumulate mod 256, whitespace commits
    logic [7:0] r_acc, r_num;
    logic       r_seen, r_num_valid;

    always_ff @(posedge sys_clk_in) begin
        if (!sys_rst_n) begin
            r_acc <= '0; r_num <= '0; r_seen <= 1'b0; r_num_valid <= 1'b0;
        end else begin
            r_num_valid <= 1'b0;
            if (r_rx_valid) begin
                if (r_rx_byte >= 8'h30 && r_rx_byte <= 8'h39) begin
                    r_acc  <= 8'(r_acc * 8'd10 + (r_rx_byte - 8'h30));
                    r_seen <= 1'b1;
                end else if (r_rx_byte == 8'h20 || r_rx_byte == 8'h0D || r_rx_byte == 8'h0A) begin
                    r_num_valid <= r_seen;
                    r_num       <= r_acc;
                    r_acc       <= '0;
                    r_seen      <= 1'b0;
                end
            end
        end
    end

    // Matrix-entry FSM and slot bookkeeping
    state_t         r_state;
    logic [2:0]     r_m, r_n;
    logic [4:0]     r_k, r_clr, r_spec;
    logic           r_slot, r_err;
    logic           r_we;
    logic [AW-1:0]  r_waddr;
    logic [7:0]     r_wdata;
    logic [1:0]     r_cnt [N_SPECS];
    logic           r_ptr [N_SPECS];
    logic           w_dim_ok, w_slot_new, w_commit;
    logic [4:0]     w_spec_new, w_mn;

    assign w_dim_ok   = (r_num >= 8'd1) && (r_num <= 8'(MAX_DIM));
    assign w_spec_new = 5'((5'(r_m) - 5'd1) * 5'(MAX_DIM) + (r_num[4:0] - 5'd1));
    assign w_slot_new = (r_cnt[w_spec_new] == 2'd2) ? r_ptr[w_spec_new] : r_cnt[w_spec_new][0];
    assign w_mn       = 5'(r_m) * 5'(r_n);
    assign w_commit   = (r_state == S_GET_DATA) &&
                        ((r_num_valid && (r_k + 5'd1 == w_mn)) || (!r_num_valid && w_confirm));

    always_ff @(posedge sys_clk_in) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE; r_m <= '0; r_n <= '0; r_k <= '0; r_clr <= '0;
            r_spec <= '0; r_slot <= 1'b0; r_err <= 1'b0;
            r_we <= 1'b0; r_waddr <= '0; r_wdata <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: if (w_confirm) begin
                    r_err <= 1'b0;
                    if (sw_pin[1:0] == 2'b00) begin
                        r_state <= S_GET_M;
                        r_k     <= '0;
                    end
                end
                S_GET_M: if (r_num_valid) begin
                    if (w_dim_ok) begin
                        r_m     <= r_num[2:0];
                        r_state <= S_GET_N;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_GET_N: if (r_num_valid) begin
                    if (w_dim_ok) begin
                        r_n     <= r_num[2:0];
                        r_spec  <= w_spec_new;
                        r_slot  <= w_slot_new;
                        r_clr   <= '0;
                        r_state <= S_CLEAR;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    r_we    <= 1'b1;
                    r_waddr <= {r_spec, r_slot, r_clr};
                    r_wdata <= '0;
                    r_clr   <= r_clr + 5'd1;
                    if (r_clr == 5'(SLOT_WORDS - 1)) begin
                        r_k     <= '0;
                        r_state <= S_GET_DATA;
                    end
                end
                S_GET_DATA: begin
                    if (r_num_valid) begin
                        r_we    <= 1'b1;
                        r_waddr <= {r_spec, r_slot, r_k};
                        r_wdata <= r_num;
                        r_k     <= r_k + 5'd1;
                    end
                    if (w_commit) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Per-spec occupancy (saturating at 2) and oldest-slot pointer
    always_ff @(posedge sys_clk_in) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < N_SPECS; i++) begin
                r_cnt[i] <= '0;
                r_ptr[i] <= 1'b0;
            end
        end else if (w_commit) begin
            r_cnt[r_spec] <= (r_cnt[r_spec] == 2'd2) ? 2'd2 : r_cnt[r_spec] + 2'd1;
            r_ptr[r_spec] <= ~r_ptr[r_spec];
        end
    end

    logic [15:0] r_led;
    always_ff @(posedge sys_clk_in) begin
        if (!sys_rst_n) r_led <= '0;
        else            r_led <= {r_err, 7'b0, r_k, 3'(r_state)};
    end

    logic [7:0] w_rdata;
    calckit_mem #(.DEPTH(MEM_WORDS), .AW(AW)) u_mem (
        .clk     (sys_clk_in),
        .i_we    (r_we),
        .i_waddr (r_waddr),
        .i_wdata (r_wdata),
        .i_raddr (r_waddr),
        .o_rdata (w_rdata)
    );

    logic w_unused;
    assign w_unused = ^{dip_pin, btn_pin[4:3], btn_pin[1:0], sw_pin[7:2], w_rdata};

    assign PC_Uart_txd    = r_txd;
    assign led_pin        = r_led;
    assign seg_cs_pin     = 8'h00;
    assign seg_data_0_pin = 8'h00;
    assign seg_data_1_pin = 8'h00;
endmodule

// File: tb/tb_calckit_top.sv
// Scoreboarded bench for calckit_top: echo bytes queued on send, popped by a TX monitor.

module tb_calckit_top;
    localparam int unsigned CLK_HZ = 1600;
    localparam int unsigned BAUD   = 100;
    localparam int unsigned BIT    = CLK_HZ / BAUD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rxd;
    logic        txd;
    logic [4:0]  btn;
    logic [7:0]  sw, dip;
    logic [15:0] led;
    logic [7:0]  seg_cs, seg_d0, seg_d1;

    calckit_top #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .sys_clk_in     (clk),
        .sys_rst_n      (rst_n),
        .PC_Uart_rxd    (rxd),
        .PC_Uart_txd    (txd),
        .btn_pin        (btn),
        .sw_pin         (sw),
        .dip_pin        (dip),
        .led_pin        (led),
        .seg_cs_pin     (seg_cs),
        .seg_data_0_pin (seg_d0),
        .seg_data_1_pin (seg_d1)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] q_echo [$];
    bit         mon_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int base_addr(input int m, input int n, input int slot);
        return (((m - 1) * 5 + (n - 1)) * 2 + slot) * 32;
    endfunction

    task automatic check_mem(input string tag, input int addr, input int exp);
        check_eq(tag, 32'(dut.u_mem.mem[addr]), 32'(exp));
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        if (stop_ok) q_echo.push_back(b);
        @(negedge clk) rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = stop_ok;
        repeat (BIT) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * BIT) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic press_confirm();
        @(negedge clk) btn[2] = 1'b1;
        repeat (2) @(negedge clk);
        btn[2] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // TX monitor: decode each echoed frame and match it against the scoreboard
    initial begin
        logic [7:0] b;
        logic       stp;
        wait (mon_en);
        forever begin
            @(negedge txd);
            repeat (BIT / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(negedge clk);
                b[i] = txd;
            end
            repeat (BIT) @(negedge clk);
            stp = txd;
            check_eq("echo_stop", 32'(stp), 32'd1);
            check_eq("echo_expected", 32'(q_echo.size() > 0), 32'd1);
            if (q_echo.size() > 0) check_eq("echo_byte", 32'(b), 32'(q_echo.pop_front()));
        end
    end

    initial begin
        int b448, b480;
        b448 = base_addr(2, 3, 0);
        b480 = base_addr(2, 3, 1);
        rst_n = 1'b0; rxd = 1'b1; btn = '0; sw = '0; dip = 8'hA5;
        repeat (4) @(negedge clk);
        check_eq("rst_led", 32'(led), 32'd0);
        check_eq("rst_txd", 32'(txd), 32'd1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        mon_en = 1'b1;

        // non-input mode ignores confirm
        sw = 8'h01;
        press_confirm();
        check_eq("mode_ignored", 32'(led[2:0]), 32'd0);
        sw = 8'h00;

        // first 2x3 -> slot 0
        press_confirm();
        check_eq("t1_get_m", 32'(led[2:0]), 32'd1);
        send_str("2 3 ");
        repeat (4 * BIT) @(negedge clk);
        check_eq("t1_get_data", 32'(led[2:0]), 32'd4);
        send_str("1 2 3 4 5 6 ");
        check_eq("t1_idle", 32'(led[2:0]), 32'd0);
        for (int i = 0; i < 6; i++) check_mem("t1_data", b448 + i, i + 1);
        for (int a = b448 + 6; a < b448 + 32; a++) check_mem("t1_pad", a, 0);

        // second 2x3 -> slot 1
        press_confirm();
        send_str("2 3 9 9 9 9 9 9 ");
        check_mem("t2_new", b480, 9);
        check_mem("t2_new_last", b480 + 5, 9);
        check_mem("t2_old_kept", b448, 1);

        // third replaces oldest (slot 0), fourth replaces slot 1
        press_confirm();
        send_str("2 3 8 8 8 8 8 8 ");
        check_mem("t3_replaced", b448, 8);
        check_mem("t3_replaced_last", b448 + 5, 8);
        check_mem("t3_kept", b480, 9);
        press_confirm();
        send_str("2 3 7 7 7 7 7 7 ");
        check_mem("t4_slot1", b480, 7);
        check_mem("t4_slot0_kept", b448, 8);

        // 2x2 with early confirm -> zero padding
        press_confirm();
        send_str("2 2 7 7 ");
        check_eq("t5_in_data", 32'(led[2:0]), 32'd4);
        check_eq("t5_k", 32'(led[7:3]), 32'd2);
        press_confirm();
        check_eq("t5_idle", 32'(led[2:0]), 32'd0);
        check_mem("t5_m0", 384, 7);
        check_mem("t5_m1", 385, 7);
        check_mem("t5_m2", 386, 0);
        check_mem("t5_m3", 387, 0);

        // invalid dimension sets error; next confirm clears it; confirm in GET_M ignored
        press_confirm();
        send_str("6 ");
        check_eq("t6_err", 32'(led[15]), 32'd1);
        check_eq("t6_idle", 32'(led[2:0]), 32'd0);
        press_confirm();
        check_eq("t6_err_clr", 32'(led[15]), 32'd0);
        check_eq("t6_get_m", 32'(led[2:0]), 32'd1);
        press_confirm();
        check_eq("t6_confirm_ignored", 32'(led[2:0]), 32'd1);

        // 1x1 with a framing-error byte in between
        send_str("1 1 ");
        repeat (4 * BIT) @(negedge clk);
        check_eq("t7_get_data", 32'(led[2:0]), 32'd4);
        send_byte(8'h35, 1'b0);
        send_str("12 ");
        check_mem("t7_val", 0, 12);
        check_eq("t7_idle", 32'(led[2:0]), 32'd0);

        repeat (12 * BIT) @(negedge clk);
        check_eq("echo_drained", 32'(q_echo.size()), 32'd0);
        check_eq("seg_blank", 32'({seg_cs, seg_d0, seg_d1}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
